imm_splitter: RTL and testbench
===============================

Name: imm_splitter

Overview:
- Converts an arbitrary 32-bit constant into the 16-bit immediate + EOp token stream consumed by the datapath immediate extender.
- Each token (imm, EOp) reproduces the constant, or half of it, when extended.
- Sits in the constant-materialisation path: the assembler-side / test-generator feeds constants in, and the tokens drive the extender plus an OR-combine step.
- Fits in one token when any extension mode can produce the value; otherwise emits a two-token upper/lower split.

Parameters:
- CNT_W, 16, width of the split statistics counter.
- EN_SHIFT2, 1, when 1 the EOp=11 class (sign-extend then shift left 2) is considered; when 0 it is never selected.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_value is valid.
- in_ready  output  1  block can accept a constant this cycle.
- in_value  input  32  constant to encode.
- out_valid  output  1  token valid.
- out_ready  input  1  consumer accepts token this cycle.
- out_imm  output  16  immediate field.
- out_eop  output  2  extension op: 00 sign-ext, 01 zero-ext, 10 load-upper (imm<<16), 11 sign-ext then <<2.
- out_or  output  1  0: token result replaces the accumulator; 1: token result is ORed into the previous result.
- out_last  output  1  final token for the current constant.
- split_cnt  output  CNT_W  number of accepted constants that needed two tokens.

Behaviour:
- Async reset: state=IDLE, out_valid=0, out_imm=0, out_eop=00, out_or=0, out_last=0, split_cnt=0. Reset mid-split drops the pending second token; nothing is replayed.
- Accept when in_valid && in_ready. in_ready = !out_valid || (out_ready && out_last), which allows back-to-back constants at one token per cycle.
- Latency: first token is registered; out_valid rises the cycle after acceptance.
- Classification of V = in_value, first match wins:
  1. V[31:15] all equal → imm=V[15:0], eop=00.
  2. V[31:16]==0 → imm=V[15:0], eop=01.
  3. V[15:0]==0 → imm=V[31:16], eop=10.
  4. EN_SHIFT2 && V[1:0]==0 && V[31:17] all equal → imm=V[17:2], eop=11.
  5. Otherwise split: token A = (V[31:16], 10, or=0, last=0), then token B = (V[15:0], 01, or=1, last=1).
- Single-token classes always have or=0, last=1.
- States:
  - IDLE: no token. Accept → ONE (classes 1-4) or SPLIT_HI (class 5).
  - ONE: token valid. On out_ready, accept a new constant if in_valid (reload ONE or SPLIT_HI), else go to IDLE.
  - SPLIT_HI: token A valid. On out_ready → SPLIT_LO. V[15:0] is held in an internal register.
  - SPLIT_LO: token B valid. On out_ready, behaves like ONE.
- Stability: while out_valid && !out_ready, out_imm, out_eop, out_or and out_last hold constant, and in_ready=0.
- split_cnt increments by 1 when a class-5 constant is accepted; it wraps modulo 2^CNT_W.
- Overlap rules: 0x00000000 is class 1. A value matching several classes takes the lowest class number. in_value is ignored when not accepted.

Test Plan:
- in_value=0xFFFF8000 → next cycle out_valid=1, imm=0x8000, eop=00, or=0, last=1; in_ready=1 once out_ready=1.
- Sequence 0x0000ABCD, 0x12340000, 0x0001FFFC sent back-to-back with out_ready=1:
  - Expected tokens: (0xABCD,01), (0x1234,10), (0x7FFF,11) on three consecutive cycles, all last=1.
  - Repeat the sequence with EN_SHIFT2=0: 0x0001FFFC splits into (0x0001,10,0,0), (0xFFFC,01,1,1).
- in_value=0x12345678 with out_ready low for 3 cycles:
  - Token A (0x1234,10,0,0) is held stable and in_ready=0.
  - Then token B (0x5678,01,1,1).
  - split_cnt=1.
- Assert reset while in SPLIT_LO for 0xDEADBEEF → out_valid=0 immediately (asynchronously), split_cnt=0, no token B after release; the next constant 0x00000001 gives (0x0001,00,0,1).
- CNT_W=2, four split constants → split_cnt sequence 1, 2, 3, 0.
- Random 32-bit constants against a model (extender plus OR-combine) → the reconstructed value equals the input and the token count matches the classification, for 10k vectors.

Source files
------------

// File: rtl/imm_splitter.sv
// Splits a 32-bit constant into one or two (imm16, EOp) tokens for the immediate
// extender; a second token, when present, is ORed onto the upper-half result.
module imm_splitter #(
    parameter int CNT_W     = 16,
    parameter bit EN_SHIFT2 = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_imm,
    output logic [1:0]       out_eop,
    output logic             out_or,
    output logic             out_last,
    output logic [CNT_W-1:0] split_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ONE, S_SPLIT_HI, S_SPLIT_LO} state_t;

    state_t           r_state, w_state_nx;
    logic [15:0]      r_imm, w_imm_nx;
    logic [1:0]       r_eop, w_eop_nx;
    logic             r_or, w_or_nx;
    logic             r_last, w_last_nx;
    logic [15:0]      r_lo, w_lo_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;

    logic w_accept, w_c1, w_c2, w_c3, w_c4;

    assign out_valid = (r_state != S_IDLE);
    assign in_ready  = !out_valid || (out_ready && r_last);
    assign w_accept  = in_valid && in_ready;

    assign out_imm   = r_imm;
    assign out_eop   = r_eop;
    assign out_or    = r_or;
    assign out_last  = r_last;
    assign split_cnt = r_cnt;

    // Extension-class tests, checked in priority order below
    assign w_c1 = (&in_value[31:15]) | ~(|in_value[31:15]);
    assign w_c2 = ~(|in_value[31:16]);
    assign w_c3 = ~(|in_value[15:0]);
    assign w_c4 = EN_SHIFT2 && (in_value[1:0] == 2'b00) &&
                  ((&in_value[31:17]) | ~(|in_value[31:17]));

    always_comb begin
        w_state_nx = r_state;
        w_imm_nx   = r_imm;
        w_eop_nx   = r_eop;
        w_or_nx    = r_or;
        w_last_nx  = r_last;
        w_lo_nx    = r_lo;
        w_cnt_nx   = r_cnt;
        if (w_accept) begin
            w_lo_nx    = in_value[15:0];
            w_or_nx    = 1'b0;
            w_last_nx  = 1'b1;
            w_state_nx = S_ONE;
            if (w_c1) begin
                w_imm_nx = in_value[15:0];
                w_eop_nx = 2'b00;
            end else if (w_c2) begin
                w_imm_nx = in_value[15:0];
                w_eop_nx = 2'b01;
            end else if (w_c3) begin
                w_imm_nx = in_value[31:16];
                w_eop_nx = 2'b10;
            end else if (w_c4) begin
                w_imm_nx = in_value[17:2];
                w_eop_nx = 2'b11;
            end else begin
                w_imm_nx   = in_value[31:16];
                w_eop_nx   = 2'b10;
                w_last_nx  = 1'b0;
                w_state_nx = S_SPLIT_HI;
                w_cnt_nx   = r_cnt + CNT_W'(1);
            end
        end else if (out_valid && out_ready) begin
            if (r_state == S_SPLIT_HI) begin
                w_state_nx = S_SPLIT_LO;
                w_imm_nx   = r_lo;
                w_eop_nx   = 2'b01;
                w_or_nx    = 1'b1;
                w_last_nx  = 1'b1;
            end else begin
                w_state_nx = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_imm   <= '0;
            r_eop   <= '0;
            r_or    <= 1'b0;
            r_last  <= 1'b0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_imm   <= w_imm_nx;
            r_eop   <= w_eop_nx;
            r_or    <= w_or_nx;
            r_last  <= w_last_nx;
            r_lo    <= w_lo_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

endmodule

// File: tb/tb_imm_splitter.sv
// Self-checking bench for imm_splitter: directed token table, multi-cycle corner
// sequences, a counter-wrap instance and randomised reconstruction through an extender model.
module tb_imm_splitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_value;
    logic        out_ready;

    logic        ir0, ov0, or0, last0;
    logic [15:0] imm0;
    logic [1:0]  eop0;
    logic [15:0] cnt0;

    logic        ir1, ov1, or1, last1;
    logic [15:0] imm1;
    logic [1:0]  eop1;
    logic [15:0] cnt1;

    logic        ir2, ov2, or2, last2;
    logic [15:0] imm2;
    logic [1:0]  eop2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_splitter #(.CNT_W(16), .EN_SHIFT2(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
        .in_value(in_value), .out_valid(ov0), .out_ready(out_ready),
        .out_imm(imm0), .out_eop(eop0), .out_or(or0), .out_last(last0), .split_cnt(cnt0));

    imm_splitter #(.CNT_W(16), .EN_SHIFT2(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
        .in_value(in_value), .out_valid(ov1), .out_ready(out_ready),
        .out_imm(imm1), .out_eop(eop1), .out_or(or1), .out_last(last1), .split_cnt(cnt1));

    imm_splitter #(.CNT_W(2), .EN_SHIFT2(1'b1)) dut_c2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
        .in_value(in_value), .out_valid(ov2), .out_ready(out_ready),
        .out_imm(imm2), .out_eop(eop2), .out_or(or2), .out_last(last2), .split_cnt(cnt2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_tok(input string name, input logic [15:0] im, input logic [1:0] e,
                           input logic o, input logic l, input logic v,
                           input logic [15:0] xim, input logic [1:0] xe,
                           input logic xo, input logic xl);
        chk({name, ".valid"}, {31'd0, v}, 32'd1);
        chk({name, ".tok"}, {12'd0, im, e, o, l}, {12'd0, xim, xe, xo, xl});
    endtask

    function automatic logic [31:0] ext(input logic [15:0] im, input logic [1:0] e);
        case (e)
            2'b00:   return {{16{im[15]}}, im};
            2'b01:   return {16'h0000, im};
            2'b10:   return {im, 16'h0000};
            default: return {{14{im[15]}}, im, 2'b00};
        endcase
    endfunction

    function automatic int tokens_needed(input logic [31:0] v);
        logic [15:0] lo, mid;
        lo  = v[15:0];
        mid = v[17:2];
        if (ext(lo, 2'b00) == v || ext(lo, 2'b01) == v || v[15:0] == 16'h0000 ||
            ext(mid, 2'b11) == v)
            return 1;
        return 2;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_value = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Push one constant into dut (out_ready high) and collect up to two tokens.
    task automatic run0(input logic [31:0] v, output int n,
                        output logic [15:0] i0, output logic [1:0] e0, output logic o0, output logic l0,
                        output logic [15:0] i1, output logic [1:0] e1, output logic o1, output logic l1);
        n = 0;
        i0 = '0; e0 = '0; o0 = 0; l0 = 0; i1 = '0; e1 = '0; o1 = 0; l1 = 0;
        @(negedge clk);
        in_valid = 1'b1; in_value = v; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_value = $urandom;
        for (int k = 0; k < 4; k++) begin
            if (ov0) begin
                if (n == 0) begin i0 = imm0; e0 = eop0; o0 = or0; l0 = last0; end
                else        begin i1 = imm0; e1 = eop0; o1 = or0; l1 = last0; end
                n++;
                if (last0 || n == 2) break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [31:0] v;
        int          n;
        logic [15:0] i0;
        logic [1:0]  e0;
        logic [15:0] i1;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n;
        logic [15:0] i0, i1;
        logic [1:0]  e0, e1;
        logic        o0, o1, l0, l1;
        logic [31:0] acc, v;

        tbl[0]  = '{32'hFFFF8000, 1, 16'h8000, 2'b00, 16'h0000};
        tbl[1]  = '{32'h00000000, 1, 16'h0000, 2'b00, 16'h0000};
        tbl[2]  = '{32'h00007FFF, 1, 16'h7FFF, 2'b00, 16'h0000};
        tbl[3]  = '{32'h00008000, 1, 16'h8000, 2'b01, 16'h0000};
        tbl[4]  = '{32'h0000ABCD, 1, 16'hABCD, 2'b01, 16'h0000};
        tbl[5]  = '{32'h12340000, 1, 16'h1234, 2'b10, 16'h0000};
        tbl[6]  = '{32'hFFFF0000, 1, 16'hFFFF, 2'b10, 16'h0000};
        tbl[7]  = '{32'hFFFE0000, 1, 16'hFFFE, 2'b10, 16'h0000};
        tbl[8]  = '{32'h80000000, 1, 16'h8000, 2'b10, 16'h0000};
        tbl[9]  = '{32'h0001FFFC, 1, 16'h7FFF, 2'b11, 16'h0000};
        tbl[10] = '{32'hFFFE0004, 1, 16'h8001, 2'b11, 16'h0000};
        tbl[11] = '{32'h12345678, 2, 16'h1234, 2'b10, 16'h5678};
        tbl[12] = '{32'hFFFDFFFC, 2, 16'hFFFD, 2'b10, 16'hFFFC};
        tbl[13] = '{32'h00010002, 2, 16'h0001, 2'b10, 16'h0002};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_value = '0;
        repeat (3) @(negedge clk);
        chk("rst.valid", {31'd0, ov0}, 32'd0);
        chk("rst.tok", {12'd0, imm0, eop0, or0, last0}, 32'd0);
        chk("rst.cnt", {16'd0, cnt0}, 32'd0);
        chk("rst.in_ready", {31'd0, ir0}, 32'd1);
        reset = 1'b0;

        // Directed single-constant table
        foreach (tbl[t]) begin
            run0(tbl[t].v, n, i0, e0, o0, l0, i1, e1, o1, l1);
            chk($sformatf("tbl%0d.n", t), n, tbl[t].n);
            chk($sformatf("tbl%0d.t0", t), {12'd0, i0, e0, o0, l0},
                {12'd0, tbl[t].i0, tbl[t].e0, 1'b0, tbl[t].n == 1});
            if (tbl[t].n == 2)
                chk($sformatf("tbl%0d.t1", t), {12'd0, i1, e1, o1, l1},
                    {12'd0, tbl[t].i1, 2'b01, 1'b1, 1'b1});
        end
        chk("tbl.split_cnt", {16'd0, cnt0}, 32'd3);

        // Back-to-back constants, one token per cycle
        do_reset();
        in_valid = 1'b1; in_value = 32'h0000ABCD; out_ready = 1'b1;
        @(negedge clk);
        chk_tok("b2b.t0", imm0, eop0, or0, last0, ov0, 16'hABCD, 2'b01, 1'b0, 1'b1);
        chk_tok("b2b_ns.t0", imm1, eop1, or1, last1, ov1, 16'hABCD, 2'b01, 1'b0, 1'b1);
        chk("b2b.in_ready", {31'd0, ir0}, 32'd1);
        in_value = 32'h12340000;
        @(negedge clk);
        chk_tok("b2b.t1", imm0, eop0, or0, last0, ov0, 16'h1234, 2'b10, 1'b0, 1'b1);
        chk_tok("b2b_ns.t1", imm1, eop1, or1, last1, ov1, 16'h1234, 2'b10, 1'b0, 1'b1);
        in_value = 32'h0001FFFC;
        @(negedge clk);
        in_valid = 1'b0;
        chk_tok("b2b.t2", imm0, eop0, or0, last0, ov0, 16'h7FFF, 2'b11, 1'b0, 1'b1);
        chk_tok("b2b_ns.tA", imm1, eop1, or1, last1, ov1, 16'h0001, 2'b10, 1'b0, 1'b0);
        chk("b2b_ns.in_ready", {31'd0, ir1}, 32'd0);
        @(negedge clk);
        chk_tok("b2b_ns.tB", imm1, eop1, or1, last1, ov1, 16'hFFFC, 2'b01, 1'b1, 1'b1);
        chk("b2b_ns.cnt", {16'd0, cnt1}, 32'd1);
        chk("b2b.cnt", {16'd0, cnt0}, 32'd0);

        // Split with a 3-cycle consumer stall
        do_reset();
        in_valid = 1'b1; in_value = 32'h12345678; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_value = 32'h0000BEEF;
        for (int k = 0; k < 3; k++) begin
            chk_tok($sformatf("stall%0d.tA", k), imm0, eop0, or0, last0, ov0,
                    16'h1234, 2'b10, 1'b0, 1'b0);
            chk($sformatf("stall%0d.in_ready", k), {31'd0, ir0}, 32'd0);
            if (k < 2) @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk_tok("stall.tB", imm0, eop0, or0, last0, ov0, 16'h5678, 2'b01, 1'b1, 1'b1);
        chk("stall.cnt", {16'd0, cnt0}, 32'd1);
        @(negedge clk);
        chk("stall.idle", {31'd0, ov0}, 32'd0);

        // Asynchronous reset while token B is pending
        do_reset();
        in_valid = 1'b1; in_value = 32'hDEADBEEF; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_tok("arst.tA", imm0, eop0, or0, last0, ov0, 16'hDEAD, 2'b10, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        chk_tok("arst.tB", imm0, eop0, or0, last0, ov0, 16'hBEEF, 2'b01, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("arst.valid", {31'd0, ov0}, 32'd0);
        chk("arst.cnt", {16'd0, cnt0}, 32'd0);
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("arst.no_replay", {31'd0, ov0}, 32'd0);
        run0(32'h00000001, n, i0, e0, o0, l0, i1, e1, o1, l1);
        chk("arst.next.n", n, 1);
        chk("arst.next.t0", {12'd0, i0, e0, o0, l0}, {12'd0, 16'h0001, 2'b00, 1'b0, 1'b1});

        // Narrow counter wraps
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_value = 32'h12345678 + k;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("wrap%0d.last", k), {31'd0, last2}, 32'd1);
            chk($sformatf("wrap%0d.cnt", k), {30'd0, cnt2}, (k + 1) % 4);
            @(negedge clk);
        end

        // Random constants reconstructed through the extender/OR model
        do_reset();
        for (int r = 0; r < 10000; r++) begin
            case ($urandom_range(0, 4))
                0:       v = $urandom;
                1:       v = {{16{1'b0}}, 16'($urandom)} ^ ({32{v[0]}} & 32'hFFFF0000);
                2:       v = {16'($urandom), 16'h0000};
                3:       begin v = $urandom; v = {{14{v[15]}}, v[15:0], 2'b00}; end
                default: v = {16'h0000, 16'($urandom)};
            endcase
            run0(v, n, i0, e0, o0, l0, i1, e1, o1, l1);
            acc = ext(i0, e0);
            if (n == 2) acc = o1 ? (acc | ext(i1, e1)) : ext(i1, e1);
            chk($sformatf("rnd%0d.value", r), acc, v);
            chk($sformatf("rnd%0d.n", r), n, tokens_needed(v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
